keypad_conditioner: RTL and testbench

//  Conditions the 12 raw keypad contacts (1-9, *, 0, #) before they reach the car simulator top level.
//  Per key: 2-FF synchroniser, tick-sampled debounce, one-cycle press/release pulses, long-press hold flag.

---
 rtl/keypad_conditioner.sv | 124 ++++++++++++
 tb/tb_keypad_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_conditioner.sv
// rtl/keypad_conditioner.sv - per-key sync, tick-sampled debounce, press/release pulses, long-press hold
// Optional auto-repeat of key_press while held: define KEY_REPEAT_EN.
module keypad_conditioner #(
    parameter int N_KEYS       = 12,
    parameter int DEB_TICKS    = 4,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_smp,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold,
    output logic              any_key
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [CNT_W-1:0]  deb_cnt_q  [N_KEYS];
    logic [CNT_W-1:0]  deb_cnt_d  [N_KEYS];
    logic [CNT_W-1:0]  hold_cnt_q [N_KEYS];
    logic [CNT_W-1:0]  hold_cnt_d [N_KEYS];
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
    logic [CNT_W-1:0]  rep_cnt_q  [N_KEYS];
    logic [CNT_W-1:0]  rep_cnt_d  [N_KEYS];
`endif

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            level_d[i]    = level_q[i];
            press_d[i]    = 1'b0;
            release_d[i]  = 1'b0;
            deb_cnt_d[i]  = deb_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
`ifdef KEY_REPEAT_EN
            rep_cnt_d[i]  = rep_cnt_q[i];
`endif
            if (tick_smp) begin
                // Any agreeing sample restarts the count, so glitches shorter than DEB_TICKS are dropped.
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i]   = ~level_q[i];
                    deb_cnt_d[i] = '0;
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
                if (level_q[i] && level_d[i] && (hold_cnt_q[i] != HOLD_MAX))
                    hold_cnt_d[i] = hold_cnt_q[i] + CNT_ONE;
`ifdef KEY_REPEAT_EN
                if (level_q[i] && level_d[i] && (hold_cnt_q[i] == HOLD_MAX)) begin
                    if (rep_cnt_q[i] == REP_LAST) begin
                        rep_cnt_d[i] = '0;
                        press_d[i]   = 1'b1;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
                    end
                end
`endif
            end
            // Clearing on the next level drops key_hold on the same edge the level falls.
            if (!level_d[i]) begin
                hold_cnt_d[i] = '0;
`ifdef KEY_REPEAT_EN
                rep_cnt_d[i]  = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
`ifdef KEY_REPEAT_EN
                rep_cnt_q[i]  <= '0;
`endif
            end
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
`ifdef KEY_REPEAT_EN
                rep_cnt_q[i]  <= rep_cnt_d[i];
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_KEYS; i++)
            key_hold[i] = (hold_cnt_q[i] == HOLD_MAX);
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign any_key     = |level_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// tb/tb_keypad_conditioner.sv - directed and random stimulus against a tick-streak reference model
module tb_keypad_conditioner;

    localparam int N    = 12;
    localparam int DEB  = 4;
    localparam int HOLD = 100;
    localparam int REP  = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick_smp = 1'b0;
    logic [N-1:0] key_raw = '0;
    logic [N-1:0] key_level, key_press, key_release, key_hold;
    logic         any_key;

    keypad_conditioner #(
        .N_KEYS(N), .DEB_TICKS(DEB), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick_smp(tick_smp), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_hold(key_hold), .any_key(any_key)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: level flips after DEB consecutive differing tick samples; hold/repeat from ticks since accept.
    logic [N-1:0] m_p1, m_p2, m_level, m_press, m_release;
    int m_streak [N];
    int m_since  [N];

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_level = '0; m_press = '0; m_release = '0;
        for (int i = 0; i < N; i++) begin
            m_streak[i] = 0;
            m_since[i]  = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] raw, input logic t);
        logic [N-1:0] seen;
        seen = m_p2;
        m_p2 = m_p1;
        m_p1 = raw;
        m_press = '0;
        m_release = '0;
        if (t) begin
            for (int i = 0; i < N; i++) begin
                if (seen[i] != m_level[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DEB) begin
                        m_streak[i]  = 0;
                        m_level[i]   = ~m_level[i];
                        m_press[i]   = m_level[i];
                        m_release[i] = ~m_level[i];
                        m_since[i]   = 0;
                        continue;
                    end
                end else begin
                    m_streak[i] = 0;
                end
                if (m_level[i]) begin
                    m_since[i]++;
`ifdef KEY_REPEAT_EN
                    if (m_since[i] > HOLD && ((m_since[i] - HOLD) % REP) == 0)
                        m_press[i] = 1'b1;
`endif
                end
            end
        end
    endtask

    function automatic logic [N-1:0] model_hold();
        logic [N-1:0] h;
        for (int i = 0; i < N; i++) h[i] = m_level[i] && (m_since[i] >= HOLD);
        return h;
    endfunction

    task automatic compare_all();
        check("level",   32'(key_level),   32'(m_level));
        check("press",   32'(key_press),   32'(m_press));
        check("release", 32'(key_release), 32'(m_release));
        check("hold",    32'(key_hold),    32'(model_hold()));
        check("any_key", 32'(any_key),     32'(|m_level));
        check("excl",    32'(key_press & key_release), 32'(0));
    endtask

    task automatic cycle(input logic [N-1:0] raw, input logic t);
        key_raw  = raw;
        tick_smp = t;
        if (!rst) model_reset();
        else model_step(raw, t);
        @(negedge clk);
        compare_all();
    endtask

    int first, pc, hc, cnt, seen;
    logic prev_hold;
    logic [N-1:0] r;

    initial begin
        model_reset();
        @(negedge clk);
        // 1: keys held through reset release
        rst = 1'b0;
        #1 compare_all();
        repeat (3) cycle(12'hFFF, 1'b1);
        rst = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle(12'hFFF, 1'b1);
            if (key_press == 12'hFFF && first < 0) first = k;
        end
        check("t1_latency", 32'(first), 32'(6));
        repeat (12) cycle('0, 1'b1);

        // 2: KEY_0 bounce then steady
        cnt = 0;
        foreach (r[i]) r[i] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cycle((k < 4) ? ((k % 2 == 0) ? 12'h400 : 12'h000) : 12'h400, 1'b1);
            cnt += int'(key_press[10]);
        end
        check("t2_press_cnt", 32'(cnt), 32'(1));
        check("t2_level", 32'(key_level[10]), 32'(1));
        repeat (12) cycle('0, 1'b1);

        // 3: STAR long press then release
        pc = -1; hc = -1;
        for (int k = 1; k <= 6 + HOLD + 5; k++) begin
            cycle(12'h200, 1'b1);
            if (key_press[9] && pc < 0) pc = k;
            if (key_hold[9] && hc < 0) hc = k;
        end
        check("t3_hold_delay", 32'(hc - pc), 32'(HOLD));
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            prev_hold = key_hold[9];
            cycle('0, 1'b1);
            if (key_release[9] && first < 0) begin
                first = k;
                check("t3_hold_before", 32'(prev_hold), 32'(1));
                check("t3_hold_drop", 32'(key_hold[9]), 32'(0));
            end
        end
        check("t3_rel_latency", 32'(first), 32'(6));

        // 4: KEY_1 and SHARP together
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(12'h801, 1'b1);
            if (key_press == 12'h801) seen++;
        end
        check("t4_joint_press", 32'(seen), 32'(1));
        check("t4_any_key", 32'(any_key), 32'(1));
        repeat (12) cycle('0, 1'b1);

        // 5: KEY_4 held 160 ticks past acceptance
        cnt = 0;
        for (int k = 0; k < 6 + 160 + 2; k++) begin
            cycle(12'h008, 1'b1);
            cnt += int'(key_press[3]);
        end
`ifdef KEY_REPEAT_EN
        check("t5_press_cnt", 32'(cnt), 32'(4));
`else
        check("t5_press_cnt", 32'(cnt), 32'(1));
`endif
        repeat (12) cycle('0, 1'b1);

        // 6: reset mid-debounce
        repeat (4) cycle(12'h010, 1'b1);
        rst = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (2) cycle('0, 1'b1);
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle('0, 1'b1);
            cnt += int'(|key_press);
        end
        check("t6_no_press", 32'(cnt), 32'(0));

        // Random: slow key changes with bounce, sparse ticks
        r = '0;
        for (int k = 0; k < 5000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 63) == 0) r[i] = ~r[i];
            cycle(r, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            cycle(r, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
